// File: rtl/rs15_9_pkg.sv
// Shared constants, types and GF(2^4) helpers for the RS(15,9) decoder path.
// Field: GF(2^4), primitive polynomial x^4+x+1 (0x13), generator root alpha = 2.
// Contents:
//   SYM_WIDTH, N_SYM, N_SYND  - symbol width, codeword length, syndrome count
//   PRIM_POLY                 - field polynomial including the x^4 term
//   sym_t, state_e            - symbol type and syndrome-engine FSM states
//   alpha_pow()               - alpha^e lookup for e = 0..14 (wraps mod 15)
//   gf_xtime()                - multiply a field element by alpha
package rs15_9_pkg;

  localparam int unsigned SYM_WIDTH = 4;
  localparam int unsigned N_SYM     = 15;
  localparam int unsigned N_SYND    = 6;
  localparam logic [4:0]  PRIM_POLY = 5'h13;

  typedef logic [SYM_WIDTH-1:0] sym_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACC
  } state_e;

  function automatic sym_t alpha_pow(input int unsigned e);
    sym_t r;
    case (e % 15)
      0:       r = 4'h1;
      1:       r = 4'h2;
      2:       r = 4'h4;
      3:       r = 4'h8;
      4:       r = 4'h3;
      5:       r = 4'h6;
      6:       r = 4'hC;
      7:       r = 4'hB;
      8:       r = 4'h5;
      9:       r = 4'hA;
      10:      r = 4'h7;
      11:      r = 4'hE;
      12:      r = 4'hF;
      13:      r = 4'hD;
      default: r = 4'h9;
    endcase
    return r;
  endfunction

  // Shift left and fold the overflowing x^4 term back in with the polynomial.
  function automatic sym_t gf_xtime(input sym_t x);
    sym_t r;
    r = {x[SYM_WIDTH-2:0], 1'b0};
    if (x[SYM_WIDTH-1]) r = r ^ PRIM_POLY[SYM_WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/gf16_const_mul.sv
// Combinational GF(2^4) multiply by the fixed constant alpha^POWER.
// The constant is known at elaboration, so the loop collapses to a small
// XOR network.
// Ports:
//   a_i - multiplicand
//   y_o - a_i * alpha^POWER
module gf16_const_mul
  import rs15_9_pkg::*;
#(
  parameter int unsigned POWER = 1
) (
  input  sym_t a_i,
  output sym_t y_o
);

  localparam sym_t COEF = alpha_pow(POWER);

  sym_t partial;
  sym_t prod;

  // Shift-and-add: for each set bit i of COEF add a_i * alpha^i.
  always_comb begin
    prod    = '0;
    partial = a_i;
    for (int unsigned i = 0; i < SYM_WIDTH; i++) begin
      if (COEF[i]) prod = prod ^ partial;
      partial = gf_xtime(partial);
    end
  end

  assign y_o = prod;

endmodule

// File: rtl/gf2_add.sv
// GF(2^m) addition: bitwise XOR of two field elements.
// Ports:
//   a_i, b_i - addends
//   y_o      - sum
module gf2_add #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/rs15_9_syndrome.sv
// RS(15,9) syndrome calculator. Received symbols arrive highest degree first
// (r_14 .. r_0); each S_j = r(alpha^j), j = 1..6, is built by Horner
// accumulation A_j <= A_j * alpha^j ^ r_i.
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   in_valid     - symbol beat valid
//   in_sop       - first symbol of a codeword (qualified by in_valid)
//   in_data      - received symbol
//   out_valid    - one-cycle pulse when out_synd/out_err are updated
//   out_synd     - {S6,S5,S4,S3,S2,S1}, S1 in the low nibble; held
//   out_err      - OR of all syndromes; held with out_synd
//   block_abort  - one-cycle pulse when a partial codeword is discarded
module rs15_9_syndrome
  import rs15_9_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic                        in_sop,
  input  logic [SYM_WIDTH-1:0]        in_data,
  output logic                        out_valid,
  output logic [N_SYND*SYM_WIDTH-1:0] out_synd,
  output logic                        out_err,
  output logic                        block_abort
);

  localparam int unsigned CNT_W = $clog2(N_SYM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SYM - 1);

  state_e                        state_q;
  logic [CNT_W-1:0]              cnt_q;
  sym_t                          acc_q      [N_SYND];
  sym_t                          acc_scaled [N_SYND];
  sym_t                          acc_d      [N_SYND];
  logic [N_SYND*SYM_WIDTH-1:0]   synd_d;
  logic                          out_valid_q;
  logic [N_SYND*SYM_WIDTH-1:0]   out_synd_q;
  logic                          out_err_q;
  logic                          abort_q;

  // One Horner step per syndrome: acc_d[j] = acc_q[j] * alpha^(j+1) ^ in_data.
  for (genvar j = 0; j < N_SYND; j++) begin : g_synd
    gf16_const_mul #(
      .POWER (j + 1)
    ) u_mul (
      .a_i (acc_q[j]),
      .y_o (acc_scaled[j])
    );

    gf2_add #(
      .WIDTH (SYM_WIDTH)
    ) u_add (
      .a_i (acc_scaled[j]),
      .b_i (in_data),
      .y_o (acc_d[j])
    );

    assign synd_d[j*SYM_WIDTH +: SYM_WIDTH] = acc_d[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      for (int unsigned j = 0; j < N_SYND; j++) acc_q[j] <= '0;
      out_valid_q <= 1'b0;
      out_synd_q  <= '0;
      out_err_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      if (in_valid) begin
        unique case (state_q)
          ST_IDLE: begin
            // Non-sop beats outside a block are silently dropped.
            if (in_sop) begin
              for (int unsigned j = 0; j < N_SYND; j++) acc_q[j] <= in_data;
              cnt_q   <= CNT_W'(1);
              state_q <= ST_ACC;
            end
          end
          ST_ACC: begin
            if (in_sop) begin
              // Restart: the partial block is thrown away, this beat is r_14.
              abort_q <= 1'b1;
              for (int unsigned j = 0; j < N_SYND; j++) acc_q[j] <= in_data;
              cnt_q   <= CNT_W'(1);
            end else begin
              for (int unsigned j = 0; j < N_SYND; j++) acc_q[j] <= acc_d[j];
              if (cnt_q == CNT_LAST) begin
                out_valid_q <= 1'b1;
                out_synd_q  <= synd_d;
                out_err_q   <= |synd_d;
                cnt_q       <= '0;
                state_q     <= ST_IDLE;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_synd    = out_synd_q;
  assign out_err     = out_err_q;
  assign block_abort = abort_q;

endmodule
